irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt aggregator downstream of the timers and other bridge devices.
- Collects their IRQ lines, latches them per-line as edge or level events, applies a software mask, and picks the lowest-index pending line.
- Raises a request to the CPU exception logic and holds it through an ack / end-of-interrupt handshake.
- Programmed through the same word-addressed bridge register interface as the timers.

Parameters:
- N_IRQ, 6, number of device interrupt inputs (1..8); IntId width fixed at 3.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- HWInt  input  N_IRQ  device IRQ lines, bit 0 highest priority
- Addr  input  2 [3:2]  register select from bridge
- WE  input  1  register write enable
- DataI  input  32  write data
- DataO  input→output  32  read data, combinational on Addr
- IntReq  output  1  interrupt request to CPU
- IntAck  input  1  CPU accepts current request (1-cycle pulse)
- IntId  output  3  index of requested/in-service line

Behaviour:
- Reset (reset==0 at posedge) clears all of the following; reset has priority over every other action, including mid-handshake:
  - MASK=0, MODE=0, PENDING=0, prev_HWInt=0
  - state=IDLE, IntReq=0, IntId=0
- Register map (Addr):
  - 0 MASK: RW, bits [N_IRQ-1:0], 1=enabled.
  - 1 PENDING: read; write-1-to-clear, edge lines only.
  - 2 MODE: RW, 1=edge, 0=level.
  - 3 STATUS: read {23'b0, inService[8], 5'b0, IntId[2:0]}; any write = EOI.
  - Unused upper bits read 0 and ignore writes.
- PENDING update at each posedge, per bit i:
  - Edge mode: set when HWInt[i]==1 && prev_HWInt[i]==0. Cleared by W1C or by IntAck for i==IntId.
  - Same-cycle set and clear: set wins.
  - Level mode: PENDING[i] <= HWInt[i]; W1C and ack have no effect.
  - prev_HWInt <= HWInt every cycle.
  - Changing MODE leaves the current bit value; the new rule applies from the next edge.
- active = PENDING & MASK. winner = lowest set index of active.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if active!=0 → REQ; IntId <= winner, IntReq <= 1 at the same edge. IntReq therefore rises exactly one cycle after the PENDING bit becomes visible.
  - REQ: IntId frozen, even if a higher-priority line arrives.
    - If IntAck: → SERVICE, IntReq <= 0, edge-mode PENDING[IntId] cleared.
    - Else if active[IntId]==0 (masked, W1C'd or level dropped): withdraw → IDLE, IntReq <= 0. Withdrawal is evaluated on the current-cycle active value.
    - Ack takes precedence over withdrawal in the same cycle.
  - SERVICE: IntReq=0, inService=1. EOI write → IDLE. Re-request possible at the earliest on the edge after returning to IDLE, i.e. IntReq is low for at least 1 cycle between requests.
  - IntAck in IDLE/SERVICE is ignored. EOI in IDLE/REQ is ignored.
- Bridge writes and FSM transitions in the same cycle both take effect. A MASK write is seen by the FSM on the following cycle.

Test Plan:
1. Reset, MODE=0x3F, MASK=0x3F; pulse HWInt[2] one cycle at t → PENDING=0x04 after edge t, IntReq=1/IntId=2 after edge t+1; IntAck → IntReq=0, PENDING=0, STATUS=0x102; EOI write → STATUS=0x002, IDLE.
2. Edge mode, HWInt[4] and HWInt[1] rise same cycle → IntId=1. Ack then EOI → second request with IntId=4 after 1-cycle gap. Ack then EOI → idle, PENDING=0.
3. Level mode line 0, MASK=0x01, HWInt[0]=1 → IntReq=1/IntId=0. Drop HWInt[0] before ack → PENDING[0]=0, IntReq=0 within 2 cycles, state IDLE, no ack needed.
4. Edge line 3 pending with MASK=0 → IntReq stays 0. Write MASK=0x08 → IntReq=1/IntId=3. In REQ, W1C PENDING with 0x08 → withdrawal, IntReq=0. Also: W1C on the same cycle as a new rising edge on that line → bit stays 1.
5. Spurious checks: IntAck pulsed in IDLE and EOI written in REQ → no state change. DataO reads at Addr 0..3 return MASK/PENDING/MODE/STATUS with upper bits 0.
6. Pull reset low while in SERVICE with PENDING=0x3F → next cycle all registers 0, IntReq=0, IntId=0. After reset release, HWInt held high needs a new 0→1 edge in edge mode before re-pending.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: bridge register bus plus IRQ lines and CPU request/ack handshake (master=bridge/CPU side, slave=irq_ctrl)
interface irq_ctrl_if #(parameter int N_IRQ = 6);
  logic [N_IRQ-1:0] HWInt;
  logic [3:2]       Addr;
  logic             WE;
  logic [31:0]      DataI;
  logic [31:0]      DataO;
  logic             IntReq;
  logic             IntAck;
  logic [2:0]       IntId;
  modport master (output HWInt, Addr, WE, DataI, IntAck, input DataO, IntReq, IntId);
  modport slave  (input HWInt, Addr, WE, DataI, IntAck, output DataO, IntReq, IntId);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge/level IRQ latch, mask, lowest-index priority pick and req/ack/EOI FSM; ports clk, reset (sync active-low), bus (irq_ctrl_if.slave)
module irq_ctrl #(parameter int N_IRQ = 6) (
  input logic       clk,
  input logic       reset,
  irq_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2;
  logic [N_IRQ-1:0] mask, mode, pending, prev, active, w1c, pending_nxt;
  logic [7:0]       act8;
  logic [1:0]       state;
  logic [2:0]       int_id, winner;
  logic             ack, eoi;
  assign active = pending & mask;
  assign act8 = 8'(active);
  assign ack = bus.IntAck && state == REQ;
  assign eoi = bus.WE && bus.Addr == 2'd3;
  assign w1c = (bus.WE && bus.Addr == 2'd1) ? bus.DataI[N_IRQ-1:0] : '0;
  always_comb begin
    winner = '0;
    pending_nxt = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (active[i]) winner = 3'(i);
    for (int i = 0; i < N_IRQ; i++)
      pending_nxt[i] = mode[i] ? (bus.HWInt[i] & ~prev[i]) | (pending[i] & ~(w1c[i] | (ack && int_id == 3'(i)))) : bus.HWInt[i];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask <= '0;
      mode <= '0;
      pending <= '0;
      prev <= '0;
      state <= IDLE;
      int_id <= '0;
    end else begin
      prev <= bus.HWInt;
      pending <= pending_nxt;
      if (bus.WE && bus.Addr == 2'd0) mask <= bus.DataI[N_IRQ-1:0];
      if (bus.WE && bus.Addr == 2'd2) mode <= bus.DataI[N_IRQ-1:0];
      if (state == IDLE && active != '0) begin
        state <= REQ;
        int_id <= winner;
      end else if (state == REQ && (ack || !act8[int_id])) state <= ack ? SERVICE : IDLE;
      else if (state == SERVICE && eoi) state <= IDLE;
    end
  end
  assign bus.IntReq = state == REQ;
  assign bus.IntId = int_id;
  assign bus.DataO = bus.Addr == 2'd0 ? 32'(mask) :
                     bus.Addr == 2'd1 ? 32'(pending) :
                     bus.Addr == 2'd2 ? 32'(mode) :
                     {23'b0, state == SERVICE, 5'b0, int_id};
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
  logic clk = 0;
  logic reset = 0;
  int errors = 0;
  int checks = 0;
  irq_ctrl_if #(.N_IRQ(6)) bus();
  irq_ctrl #(.N_IRQ(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    chk(tag, bus.DataO, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.WE = 1;
    bus.Addr = a;
    bus.DataI = d;
    step();
    bus.WE = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.HWInt = 0;
    bus.Addr = 0;
    bus.WE = 0;
    bus.DataI = 0;
    bus.IntAck = 0;
    repeat (2) step();
    chk("rst_req", 32'(bus.IntReq), 0);
    chk("rst_id", 32'(bus.IntId), 0);
    rd("rst_status", 3, 0);
    reset = 1;
    // 1: single edge pulse, ack, EOI
    wr(2, 32'h3F);
    wr(0, 32'h3F);
    bus.HWInt = 6'h04;
    step();
    bus.HWInt = 0;
    rd("t1_pend", 1, 32'h04);
    chk("t1_req0", 32'(bus.IntReq), 0);
    step();
    chk("t1_req1", 32'(bus.IntReq), 1);
    chk("t1_id", 32'(bus.IntId), 2);
    bus.IntAck = 1;
    step();
    bus.IntAck = 0;
    chk("t1_req_ack", 32'(bus.IntReq), 0);
    rd("t1_pend_ack", 1, 0);
    rd("t1_status_svc", 3, 32'h102);
    wr(3, 0);
    rd("t1_status_eoi", 3, 32'h002);
    // 2: simultaneous edges, priority, re-request after gap
    bus.HWInt = 6'h12;
    step();
    bus.HWInt = 0;
    step();
    chk("t2_req", 32'(bus.IntReq), 1);
    chk("t2_id1", 32'(bus.IntId), 1);
    bus.IntAck = 1;
    step();
    bus.IntAck = 0;
    rd("t2_pend", 1, 32'h10);
    wr(3, 0);
    chk("t2_gap", 32'(bus.IntReq), 0);
    step();
    chk("t2_req2", 32'(bus.IntReq), 1);
    chk("t2_id4", 32'(bus.IntId), 4);
    bus.IntAck = 1;
    step();
    bus.IntAck = 0;
    wr(3, 0);
    rd("t2_pend_end", 1, 0);
    chk("t2_idle", 32'(bus.IntReq), 0);
    // 3: level line withdraws when dropped
    wr(2, 32'h3E);
    wr(0, 32'h01);
    bus.HWInt = 6'h01;
    step();
    step();
    chk("t3_req", 32'(bus.IntReq), 1);
    chk("t3_id", 32'(bus.IntId), 0);
    bus.HWInt = 0;
    step();
    rd("t3_pend", 1, 0);
    step();
    chk("t3_withdraw", 32'(bus.IntReq), 0);
    rd("t3_status", 3, 0);
    // 4: mask gating, W1C withdrawal, set beats W1C
    wr(2, 32'h3F);
    wr(0, 0);
    bus.HWInt = 6'h08;
    step();
    bus.HWInt = 0;
    step();
    chk("t4_masked", 32'(bus.IntReq), 0);
    rd("t4_pend", 1, 32'h08);
    wr(0, 32'h08);
    chk("t4_mask_lag", 32'(bus.IntReq), 0);
    step();
    chk("t4_req", 32'(bus.IntReq), 1);
    chk("t4_id", 32'(bus.IntId), 3);
    wr(1, 32'h08);
    chk("t4_req_hold", 32'(bus.IntReq), 1);
    step();
    chk("t4_withdraw", 32'(bus.IntReq), 0);
    rd("t4_pend_clr", 1, 0);
    wr(0, 0);
    bus.HWInt = 6'h08;
    wr(1, 32'h08);
    bus.HWInt = 0;
    rd("t4_set_wins", 1, 32'h08);
    wr(1, 32'h08);
    rd("t4_w1c", 1, 0);
    // 5: spurious ack/EOI, register readback
    bus.IntAck = 1;
    step();
    bus.IntAck = 0;
    chk("t5_ack_idle", 32'(bus.IntReq), 0);
    rd("t5_status_idle", 3, 32'h003);
    wr(0, 32'h3F);
    bus.HWInt = 6'h20;
    step();
    bus.HWInt = 0;
    step();
    chk("t5_req", 32'(bus.IntReq), 1);
    chk("t5_id", 32'(bus.IntId), 5);
    wr(3, 0);
    chk("t5_eoi_req", 32'(bus.IntReq), 1);
    rd("t5_status_req", 3, 32'h005);
    bus.IntAck = 1;
    step();
    bus.IntAck = 0;
    rd("t5_status_svc", 3, 32'h105);
    wr(0, 32'hFFFF_FFE5);
    rd("t5_mask", 0, 32'h25);
    wr(2, 32'hABCD_EF2A);
    rd("t5_mode", 2, 32'h2A);
    wr(2, 32'hFFFF_FFFF);
    rd("t5_mode_all", 2, 32'h3F);
    bus.HWInt = 6'h3F;
    step();
    rd("t5_pend_all", 1, 32'h3F);
    rd("t5_status_still", 3, 32'h105);
    // 6: reset mid-service, held-high lines need a fresh edge
    reset = 0;
    step();
    chk("t6_req", 32'(bus.IntReq), 0);
    chk("t6_id", 32'(bus.IntId), 0);
    rd("t6_mask", 0, 0);
    rd("t6_pend", 1, 0);
    rd("t6_mode", 2, 0);
    rd("t6_status", 3, 0);
    reset = 1;
    wr(2, 32'h3F);
    wr(1, 32'h3F);
    step();
    rd("t6_no_repend", 1, 0);
    bus.HWInt = 6'h3D;
    step();
    bus.HWInt = 6'h3F;
    step();
    rd("t6_new_edge", 1, 32'h02);
    chk("t6_masked", 32'(bus.IntReq), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
